// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type, idle line level and index-width helper.
// Used by both the transmitter and its paired receiver.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  function automatic int uart_idx_w(int bits);
    return (bits <= 1) ? 1 : $clog2(bits);
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding an LSB-first frame shifter.
// Bit timing comes from an external baud_tick strobe shared with the receiver.
module uart_tx #(
  parameter int unsigned DATA_BITS = 3,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);
  import uart_pkg::*;

  localparam int IDX_W = uart_idx_w(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_t state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 hold_valid_q, hold_valid_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [IDX_W-1:0]     next_idx;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 line_q, line_d;
  logic                 done_q, done_d;

  assign next_idx  = bit_idx_q + IDX_W'(1);
  assign tx_ready  = ~hold_valid_q;
  assign tx_serial = line_q;
  assign tx_done   = done_q;
  assign tx_busy   = (state_q != IDLE) || hold_valid_q;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    stop_cnt_d   = stop_cnt_q;
    line_d       = line_q;
    done_d       = 1'b0;

    // Accept needs an empty holder and transfer needs a full one, so they never collide.
    if (tx_valid && !hold_valid_q) begin
      hold_d       = tx_data;
      hold_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        line_d = UART_IDLE_LEVEL;
        if (hold_valid_q && baud_tick) begin
          shift_d      = hold_q;
          hold_valid_d = 1'b0;
          line_d       = 1'b0;
          state_d      = START;
        end
      end
      START: begin
        if (baud_tick) begin
          line_d    = shift_q[0];
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_idx_q == IDX_LAST) begin
            line_d     = UART_IDLE_LEVEL;
            stop_cnt_d = 1'b0;
            state_d    = STOP;
          end else begin
            bit_idx_d = next_idx;
            line_d    = shift_q[next_idx];
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (stop_cnt_q != STOP_LAST) begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end else begin
            done_d = 1'b1;
            if (hold_valid_q) begin
              shift_d      = hold_q;
              hold_valid_d = 1'b0;
              line_d       = 1'b0;
              state_d      = START;
            end else begin
              line_d  = UART_IDLE_LEVEL;
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        line_d  = UART_IDLE_LEVEL;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      stop_cnt_q   <= 1'b0;
      line_q       <= UART_IDLE_LEVEL;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      stop_cnt_q   <= stop_cnt_d;
      line_q       <= line_d;
      done_q       <= done_d;
    end
  end

endmodule
